// File: rtl/collision_check_arbiter.sv
// rtl/collision_check_arbiter.sv - round-robin arbiter time-sharing one collision detector
// Grants one move-test at a time, holds detector inputs for DETECT_LATENCY cycles, then samples move_allowed.
module collision_check_arbiter #(
  parameter int DETECT_LATENCY = 1,
  parameter int COORD_W        = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic [3:0]             enable,
  input  logic [4*COORD_W-1:0]   test_x_in,
  input  logic [4*COORD_W-1:0]   test_y_in,
  input  logic                   move_allowed,
  output logic [COORD_W-1:0]     det_test_x,
  output logic [COORD_W-1:0]     det_test_y,
  output logic [1:0]             det_character,
  output logic                   det_valid,
  output logic [3:0]             done,
  output logic [3:0]             result,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [1:0]           last_grant, last_grant_nxt;
  logic [COORD_W-1:0]   x_nxt, y_nxt;
  logic [1:0]           char_nxt;
  logic                 valid_nxt;
  logic [3:0]           done_nxt, result_nxt;
  logic [3:0]           eligible;
  logic [1:0]           winner, cand;
  logic                 found;

  // Rotating scan starting just after the last serviced requester.
  always_comb begin
    eligible = req & enable;
    winner   = last_grant;
    cand     = last_grant;
    found    = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    x_nxt          = det_test_x;
    y_nxt          = det_test_y;
    char_nxt       = det_character;
    valid_nxt      = det_valid;
    done_nxt       = 4'b0000;
    result_nxt     = result;
    case (state)
      S_IDLE: begin
        x_nxt     = '0;
        y_nxt     = '0;
        char_nxt  = 2'd0;
        valid_nxt = 1'b0;
        if (found) begin
          for (int i = 0; i < 4; i++) begin
            if (winner == 2'(i)) begin
              x_nxt = test_x_in[i*COORD_W +: COORD_W];
              y_nxt = test_y_in[i*COORD_W +: COORD_W];
            end
          end
          char_nxt  = winner;
          valid_nxt = 1'b1;
          cnt_nxt   = 4'(DETECT_LATENCY);
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          result_nxt[det_character] = move_allowed;
          done_nxt[det_character]   = 1'b1;
          state_nxt                 = S_RESPOND;
        end
      end
      S_RESPOND: begin
        x_nxt          = '0;
        y_nxt          = '0;
        char_nxt       = 2'd0;
        valid_nxt      = 1'b0;
        last_grant_nxt = det_character;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      last_grant    <= 2'd3;
      det_test_x    <= '0;
      det_test_y    <= '0;
      det_character <= 2'd0;
      det_valid     <= 1'b0;
      done          <= 4'b0000;
      result        <= 4'b0000;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      last_grant    <= last_grant_nxt;
      det_test_x    <= x_nxt;
      det_test_y    <= y_nxt;
      det_character <= char_nxt;
      det_valid     <= valid_nxt;
      done          <= done_nxt;
      result        <= result_nxt;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
